// File: rtl/uart_pkg.sv
// uart_pkg: FSM states, serial line constants and parity helper
// shared by uart_tx_frame. PARITY state exists only with UART_TX_PARITY_EN.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_e;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   // Even parity of up to 9 data bits, inverted for odd sense.
   function automatic logic calc_parity(
      input logic [8:0] d,
      input logic       odd
   );
      return (^d) ^ odd;
   endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if: host-side valid/ready word handshake.
// master drives tx_valid/tx_data; slave (transmitter) drives tx_ready.
interface uart_tx_frame_if #(
   parameter int DATA_W = 8
);
   logic              tx_valid;
   logic [DATA_W-1:0] tx_data;
   logic              tx_ready;

   modport master (output tx_valid, output tx_data, input tx_ready);
   modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit timer counting 0..BAUD_DIV-1.
// Ports: clk, rst_n, clear (hold at 0), tick (one cycle at wrap).
module uart_baud_gen #(
   parameter int BAUD_DIV = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic tick
);
   localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clear || (cnt_q == LAST)) cnt_d = '0;
   end

   assign tick = !clear && (cnt_q == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter, start + DATA_W bits LSB first + optional
// parity (UART_TX_PARITY_EN) + STOP_BITS stop bits. Ports: clk, rst_n,
// bus (slave handshake), tx (serial line), busy, done (frame-end pulse).
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int STOP_BITS  = 1,
   parameter int BAUD_DIV   = 16,
   parameter int PARITY_ODD = 0
) (
   input  logic            clk,
   input  logic            rst_n,
   uart_tx_frame_if.slave  bus,
   output logic            tx,
   output logic            busy,
   output logic            done
);
   localparam int BW = $clog2(DATA_W + 1);
   localparam logic [BW-1:0] LAST_DATA = BW'(DATA_W - 1);
   localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [BW-1:0]     bit_q, bit_d;
   logic              tx_q, tx_d;
   logic              done_q, done_d;
   logic              tick;
   logic              accept;
   logic              idle;
`ifdef UART_TX_PARITY_EN
   logic              par_q, par_d;
`endif

   assign idle         = (state_q == IDLE);
   assign bus.tx_ready = idle;
   assign accept       = bus.tx_valid && idle;

   // Timer held cleared while idle, so it starts at 0 on cycle 1.
   uart_baud_gen #(
      .BAUD_DIV (BAUD_DIV)
   ) u_baud (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (idle),
      .tick  (tick)
   );

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      tx_d    = tx_q;
      done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      unique case (state_q)
         IDLE: if (accept) begin
            state_d = START;
            shift_d = bus.tx_data;
            bit_d   = '0;
            tx_d    = START_BIT;
`ifdef UART_TX_PARITY_EN
            par_d   = calc_parity(9'(bus.tx_data), PARITY_ODD != 0);
`endif
         end
         START: if (tick) begin
            state_d = DATA;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
         end
         // bit_q is the index of the data bit currently on the line.
         DATA: if (tick) begin
            if (bit_q == LAST_DATA) begin
               bit_d   = '0;
`ifdef UART_TX_PARITY_EN
               state_d = PARITY;
               tx_d    = par_q;
`else
               state_d = STOP;
               tx_d    = STOP_BIT;
`endif
            end else begin
               bit_d   = bit_q + 1'b1;
               tx_d    = shift_q[0];
               shift_d = shift_q >> 1;
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: if (tick) begin
            state_d = STOP;
            tx_d    = STOP_BIT;
         end
`endif
         STOP: if (tick) begin
            if (bit_q == LAST_STOP) begin
               state_d = IDLE;
               bit_d   = '0;
               done_d  = 1'b1;
            end else begin
               bit_d   = bit_q + 1'b1;
            end
            tx_d = STOP_BIT;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         shift_q <= '0;
         bit_q   <= '0;
         tx_q    <= STOP_BIT;
         done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign tx   = tx_q;
   assign busy = !idle;
   assign done = done_q;
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: two transmitters (1 and 2 stop bits, even/odd parity)
// checked cycle by cycle against a frame-level model.
module tb_uart_tx_frame;
   localparam int DW = 8;
   localparam int BD = 4;
`ifdef UART_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       vld [2];
   logic [7:0] dat [2];
   wire        txo [2];
   wire        bsy [2];
   wire        dn  [2];
   wire        rdy [2];

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   uart_tx_frame_if #(.DATA_W(DW)) if0 ();
   uart_tx_frame_if #(.DATA_W(DW)) if1 ();

   assign if0.tx_valid = vld[0];
   assign if0.tx_data  = dat[0];
   assign if1.tx_valid = vld[1];
   assign if1.tx_data  = dat[1];
   assign rdy[0] = if0.tx_ready;
   assign rdy[1] = if1.tx_ready;

   uart_tx_frame #(
      .DATA_W(DW), .STOP_BITS(1), .BAUD_DIV(BD), .PARITY_ODD(0)
   ) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(if0.slave),
      .tx(txo[0]), .busy(bsy[0]), .done(dn[0])
   );

   uart_tx_frame #(
      .DATA_W(DW), .STOP_BITS(2), .BAUD_DIV(BD), .PARITY_ODD(1)
   ) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(if1.slave),
      .tx(txo[1]), .busy(bsy[1]), .done(dn[1])
   );

   function automatic int nbits(input int k);
      return 1 + DW + P + ((k == 0) ? 1 : 2);
   endfunction

   // Frame bit idx: 0 start, 1..DW data LSB first, parity, then stops.
   function automatic logic exp_bit(input int k, input logic [7:0] w,
                                    input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= DW) return w[idx-1];
      if (P == 1 && idx == DW + 1) return (^w) ^ (k == 1);
      return 1'b1;
   endfunction

   task automatic start(input int k, input logic [7:0] w);
      @(negedge clk);
      vld[k] = 1'b1;
      dat[k] = w;
      vectors++;
      if (rdy[k] !== 1'b1) begin
         errors++;
         $display("FAIL start%0d: tx_ready=%b need 1", k, rdy[k]);
      end
      @(posedge clk); #1;
   endtask

   // Entered #1 after the accept edge; leaves #1 into the done cycle.
   task automatic run_frame(input int k, input logic [7:0] w,
                            input bit hold, input logic [7:0] nxt,
                            input bit scramble);
      int   n;
      logic eb;
      n = nbits(k) * BD;
      for (int c = 1; c <= n; c++) begin
         eb = exp_bit(k, w, (c - 1) / BD);
         vectors++;
         if (txo[k] !== eb || rdy[k] !== 1'b0 ||
             bsy[k] !== 1'b1 || dn[k] !== 1'b0) begin
            errors++;
            $display("FAIL frame%0d w=%h cyc %0d: tx=%b rdy=%b busy=%b done=%b need tx=%b rdy=0 busy=1 done=0",
                     k, w, c, txo[k], rdy[k], bsy[k], dn[k], eb);
         end
         if (c == 1) begin
            if (hold) dat[k] = nxt;
            else      vld[k] = 1'b0;
         end
         if (scramble) dat[k] = 8'($urandom);
         @(posedge clk); #1;
      end
      vectors++;
      if (dn[k] !== 1'b1 || rdy[k] !== 1'b1 ||
          txo[k] !== 1'b1 || bsy[k] !== 1'b0) begin
         errors++;
         $display("FAIL done%0d w=%h: done=%b rdy=%b tx=%b busy=%b need 1 1 1 0",
                  k, w, dn[k], rdy[k], txo[k], bsy[k]);
      end
   endtask

   task automatic idle_check(input int k);
      @(posedge clk); #1;
      vectors++;
      if (dn[k] !== 1'b0 || txo[k] !== 1'b1 || rdy[k] !== 1'b1) begin
         errors++;
         $display("FAIL idle%0d: done=%b tx=%b rdy=%b need 0 1 1",
                  k, dn[k], txo[k], rdy[k]);
      end
   endtask

   task automatic test_reset();
      logic [7:0] w;
      w = 8'($urandom);
      rst_n  = 1'b0;
      vld[0] = 1'b1;
      vld[1] = 1'b1;
      dat[0] = w;
      dat[1] = 8'($urandom);
      repeat (3) begin
         @(posedge clk); #1;
         for (int k = 0; k < 2; k++) begin
            vectors++;
            if (txo[k] !== 1'b1 || rdy[k] !== 1'b1 ||
                bsy[k] !== 1'b0 || dn[k] !== 1'b0) begin
               errors++;
               $display("FAIL reset%0d: tx=%b rdy=%b busy=%b done=%b need 1 1 0 0",
                        k, txo[k], rdy[k], bsy[k], dn[k]);
            end
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      vld[1] = 1'b0;
      vectors++;
      if (bsy[1] !== 1'b1) begin
         errors++;
         $display("FAIL reset_accept1: busy=%b need 1", bsy[1]);
      end
      run_frame(0, w, 1'b0, 8'h00, 1'b0);
      repeat (10) @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      start(0, 8'hA5);
      run_frame(0, 8'hA5, 1'b0, 8'h00, 1'b0);
      idle_check(0);
   endtask

   task automatic test_random();
      logic [7:0] w;
      for (int i = 0; i < 6; i++) begin
         w = 8'($urandom);
         start(i % 2, w);
         run_frame(i % 2, w, 1'b0, 8'h00, 1'b0);
         idle_check(i % 2);
      end
   endtask

   task automatic test_parity();
      for (int k = 0; k < 2; k++) begin
         start(k, 8'h07);
         run_frame(k, 8'h07, 1'b0, 8'h00, 1'b0);
         idle_check(k);
      end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 2; k++) begin
         start(k, 8'h00);
         run_frame(k, 8'h00, 1'b1, 8'hFF, 1'b0);
         @(posedge clk); #1;
         run_frame(k, 8'hFF, 1'b0, 8'h00, 1'b0);
         idle_check(k);
      end
   endtask

   task automatic test_abort();
      logic [7:0] w;
      logic       eb;
      w = 8'($urandom);
      start(0, w);
      vld[0] = 1'b0;
      for (int c = 1; c <= 4 * BD + 2; c++) begin
         eb = exp_bit(0, w, (c - 1) / BD);
         vectors++;
         if (txo[0] !== eb) begin
            errors++;
            $display("FAIL abort_pre cyc %0d: tx=%b need %b", c, txo[0], eb);
         end
         @(posedge clk); #1;
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (txo[0] !== 1'b1 || bsy[0] !== 1'b0 || rdy[0] !== 1'b1) begin
         errors++;
         $display("FAIL abort_async: tx=%b busy=%b rdy=%b need 1 0 1",
                  txo[0], bsy[0], rdy[0]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 60; c++) begin
         @(posedge clk); #1;
         vectors++;
         if (dn[0] !== 1'b0 || txo[0] !== 1'b1) begin
            errors++;
            $display("FAIL abort_post cyc %0d: done=%b tx=%b need 0 1",
                     c, dn[0], txo[0]);
         end
      end
      w = 8'($urandom);
      start(0, w);
      run_frame(0, w, 1'b0, 8'h00, 1'b0);
      idle_check(0);
   endtask

   task automatic test_scramble();
      logic [7:0] w;
      for (int k = 0; k < 2; k++) begin
         w = 8'($urandom);
         start(k, w);
         run_frame(k, w, 1'b0, 8'h00, 1'b1);
         idle_check(k);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_random();
      test_parity();
      test_back_to_back();
      test_abort();
      test_scramble();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, errors);
      $finish;
   end
endmodule
